// File: rtl/vga_tile_writer_pkg.sv
// Shared constants for the 150x150 tile layout in video memory.
// Used by both the tile writer and the read-side address translator.
package vga_tile_pkg;

  localparam int TILE_W      = 150;
  localparam int TILE_H      = 150;
  localparam int TILE_PIXELS = TILE_W * TILE_H;
  localparam int MEM_ADDR_W  = 17;

  localparam logic [MEM_ADDR_W-1:0] TILE_BASE [3] = '{17'h00000, 17'h057E4, 17'h0AFC8};
  // Location that always reads back as zero; parked address when idle.
  localparam logic [MEM_ADDR_W-1:0] BLANK_ADDR = 17'h107AC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  function automatic logic [MEM_ADDR_W-1:0] tile_base(input logic [1:0] sel);
    case (sel)
      2'd0:    return TILE_BASE[0];
      2'd1:    return TILE_BASE[1];
      2'd2:    return TILE_BASE[2];
      default: return BLANK_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/vga_tile_writer_if.sv
// Pixel stream in (valid/ready) and video RAM write port out.
// The pixel producer / memory side is master, the tile writer is slave.
interface vga_tile_writer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;

  modport master (
    output pix_data, pix_valid,
    input  pix_ready, mem_address, mem_data, mem_we
  );

  modport slave (
    input  pix_data, pix_valid,
    output pix_ready, mem_address, mem_data, mem_we
  );
endinterface

// File: rtl/vga_tile_writer_raster_counter.sv
// Column/row position of the pixel currently offered to a tile.
// 'last' flags the bottom-right pixel so the writer can finish the fill.
module tile_raster_counter
  import vga_tile_pkg::*;
#(
  parameter int TILE_W = vga_tile_pkg::TILE_W,
  parameter int TILE_H = vga_tile_pkg::TILE_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] col,
  output logic [7:0] row,
  output logic       last
);

  logic [7:0] col_q;
  logic [7:0] row_q;
  logic       col_wrap;

  assign col_wrap = (col_q == 8'(TILE_W - 1));
  assign last     = col_wrap && (row_q == 8'(TILE_H - 1));
  assign col      = col_q;
  assign row      = row_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= last ? 8'd0 : row_q + 8'd1;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_tile_writer.sv
// Fills one 150x150 tile of video RAM from a pixel stream, one registered
// write per accepted pixel, addressed by an incrementing pointer.
module vga_tile_writer
  import vga_tile_pkg::*;
#(
  parameter int TILE_W = vga_tile_pkg::TILE_W,
  parameter int TILE_H = vga_tile_pkg::TILE_H,
  parameter int ADDR_W = vga_tile_pkg::MEM_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic             clock25,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       tile_sel,
  input  logic             abort,
  vga_tile_writer_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  fill_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;

  logic       hs;
  logic       start_ok;
  logic       last;
  logic [7:0] col;
  logic [7:0] row;
  logic       raster_unused;

  assign hs       = bus.pix_valid && (state_q == ST_FILL);
  assign start_ok = start && (state_q == ST_IDLE) && (tile_sel != 2'd3);

  tile_raster_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_raster (
    .clk  (clock25),
    .rst  (reset),
    .clr  (start_ok),
    .en   (hs),
    .col  (col),
    .row  (row),
    .last (last)
  );

  // Raster position is only needed internally for 'last'.
  assign raster_unused = ^{col, row};

  always_ff @(posedge clock25) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= ADDR_W'(BLANK_ADDR);
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= hs;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (hs) begin
        addr_q <= ptr_q;
        data_q <= bus.pix_data;
        // Hold on the last pixel so the pointer stays inside the tile.
        if (!last) ptr_q <= ptr_q + ADDR_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (tile_sel != 2'd3) begin
              ptr_q   <= ADDR_W'(tile_base(tile_sel));
              state_q <= ST_FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (hs && last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pix_ready   = (state_q == ST_FILL);
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_we      = we_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_vga_tile_writer.sv
// Directed/randomised bench for vga_tile_writer against a behavioural model
// of the fill sequence and the expected write stream.
module tb_vga_tile_writer;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int NPIX   = 22500;
  localparam logic [16:0] BLANK = 17'h107AC;

  logic       clock25 = 1'b0;
  logic       reset, start, abort, busy, done, err;
  logic [1:0] tile_sel;

  vga_tile_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_tile_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock25  (clock25),
    .reset    (reset),
    .start    (start),
    .tile_sel (tile_sel),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #20 clock25 = ~clock25;

  typedef struct packed {
    int          cyc;
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  wr_t         exp_q[$];
  logic [16:0] obs_a[$];
  logic [7:0]  obs_d[$];
  int wr_cnt, wr_bad, done_cnt, done_alone, err_cnt, ctl_bad;
  wr_t e_mon;

  // Model of the fill: 0 idle, 1 filling, 2 done-cycle.
  int m_st = 0;
  int m_base = 0;
  int m_cnt = 0;
  logic m_err = 1'b0;

  always @(posedge clock25) cyc++;

  always @(negedge clock25) begin
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      obs_a.push_back(bus.mem_address);
      obs_d.push_back(bus.mem_data);
      if (exp_q.size() == 0) begin
        wr_bad++;
      end else begin
        e_mon = exp_q.pop_front();
        if (e_mon.a !== bus.mem_address || e_mon.d !== bus.mem_data || e_mon.cyc != cyc)
          wr_bad++;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (bus.mem_we !== 1'b1) done_alone++;
    end
    if (err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_addr(input int i);
    if (i >= 0 && i < obs_a.size()) return 32'(obs_a[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] obs_data(input int i);
    if (i >= 0 && i < obs_d.size()) return 32'(obs_d[i]);
    return 'x;
  endfunction

  task automatic clr_stats();
    obs_a.delete();
    obs_d.delete();
    wr_cnt = 0; wr_bad = 0; done_cnt = 0; done_alone = 0; err_cnt = 0; ctl_bad = 0;
  endtask

  // One clock cycle: drive inputs, check control outputs against the model,
  // advance the model, then move to just after the next rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic s,
                      input logic [1:0] ts, input logic ab, input logic rs);
    logic hs;
    bus.pix_valid = v; bus.pix_data = d;
    start = s; tile_sel = ts; abort = ab; reset = rs;
    if (bus.pix_ready !== (m_st == 1) || busy !== (m_st != 0) ||
        done !== (m_st == 2) || err !== m_err)
      ctl_bad++;
    hs = v && (m_st == 1);
    m_err = 1'b0;
    if (rs) begin
      m_st = 0;
    end else begin
      if (hs) begin
        exp_q.push_back('{cyc: cyc + 1, a: 17'(m_base + m_cnt), d: d});
        m_cnt++;
      end
      case (m_st)
        0: if (s) begin
             if (ts < 2'd3) begin
               m_st = 1; m_base = int'(ts) * NPIX; m_cnt = 0;
             end else begin
               m_err = 1'b1;
             end
           end
        1: if (ab) m_st = 0;
           else if (hs && m_cnt == NPIX) m_st = 2;
        default: m_st = 0;
      endcase
    end
    @(posedge clock25); #1;
  endtask

  initial begin
    int i;
    reset = 1'b1; start = 1'b0; abort = 1'b0; tile_sel = 2'd0;
    bus.pix_valid = 1'b0; bus.pix_data = '0;
    repeat (3) @(posedge clock25);
    #1;
    chk("rst_addr",  32'(bus.mem_address), 32'(BLANK));
    chk("rst_data",  32'(bus.mem_data), 32'h0);
    chk("rst_we",    32'(bus.mem_we), 32'h0);
    chk("rst_ready", 32'(bus.pix_ready), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_err",   32'(err), 32'h0);

    // Idle with random stimulus on the pixel port.
    clr_stats();
    repeat (10) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
    chk("idle_ctl",    32'(ctl_bad), 32'h0);
    chk("idle_writes", 32'(wr_cnt), 32'h0);
    chk("idle_addr",   32'(bus.mem_address), 32'(BLANK));

    // Tile 1, back-to-back pixels, value = index mod 256.
    clr_stats();
    step(1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 1'b0);
    for (int k = 0; k < NPIX; k++) step(1'b1, 8'(k), 1'b0, 2'd1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t1_first_addr", obs_addr(0), 32'h057E4);
    chk("t1_first_data", obs_data(0), 32'h00);
    chk("t1_idx150",     obs_addr(150), 32'h0587A);
    chk("t1_last_addr",  obs_addr(NPIX - 1), 32'h0AFC7);
    chk("t1_last_data",  obs_data(NPIX - 1), 32'hE3);
    chk("t1_count",      32'(wr_cnt), 32'(NPIX));
    chk("t1_stream",     32'(wr_bad), 32'h0);
    chk("t1_done_cnt",   32'(done_cnt), 32'h1);
    chk("t1_done_align", 32'(done_alone), 32'h0);
    chk("t1_ctl",        32'(ctl_bad), 32'h0);

    // Tile 2, pix_valid toggling, random data.
    clr_stats();
    step(1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 1'b0);
    i = 0;
    while (m_cnt < NPIX && i < 50000) begin
      step(1'(i % 2 == 0), 8'($urandom), 1'b0, 2'd2, 1'b0, 1'b0);
      i++;
    end
    repeat (3) step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t2_first_addr", obs_addr(0), 32'h0AFC8);
    chk("t2_last_addr",  obs_addr(NPIX - 1), 32'h107AB);
    chk("t2_count",      32'(wr_cnt), 32'(NPIX));
    chk("t2_stream",     32'(wr_bad), 32'h0);
    chk("t2_done_cnt",   32'(done_cnt), 32'h1);
    chk("t2_ctl",        32'(ctl_bad), 32'h0);

    // Rejected tile index.
    clr_stats();
    step(1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 1'b0);
    repeat (4) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t3_err_cnt", 32'(err_cnt), 32'h1);
    chk("t3_writes",  32'(wr_cnt), 32'h0);
    chk("t3_busy",    32'(busy), 32'h0);
    chk("t3_ctl",     32'(ctl_bad), 32'h0);

    // Tile 0 with random valid, a stray start mid-fill, abort on pixel 300.
    clr_stats();
    step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
    i = 0;
    while (m_cnt < 299 && i < 3000) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'(i == 50), 2'd2, 1'b0, 1'b0);
      i++;
    end
    step(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b1, 1'b0);
    chk("t4_busy_after", 32'(busy), 32'h0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t4_last_addr", obs_addr(299), 32'h0012B);
    chk("t4_count",     32'(wr_cnt), 32'd300);
    chk("t4_no_done",   32'(done_cnt), 32'h0);
    chk("t4_no_err",    32'(err_cnt), 32'h0);
    chk("t4_stream",    32'(wr_bad), 32'h0);
    chk("t4_ctl",       32'(ctl_bad), 32'h0);

    // Reset in the middle of a tile 0 fill, then refill.
    clr_stats();
    step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 1000; k++) step(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b1);
    chk("t5_rst_we",    32'(bus.mem_we), 32'h0);
    chk("t5_rst_addr",  32'(bus.mem_address), 32'(BLANK));
    chk("t5_rst_busy",  32'(busy), 32'h0);
    chk("t5_pre_count", 32'(wr_cnt), 32'd1000);
    clr_stats();
    step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_refill_addr", obs_addr(0), 32'h0);
    chk("t5_refill_cnt",  32'(wr_cnt), 32'd20);
    chk("t5_stream",      32'(wr_bad), 32'h0);
    chk("t5_ctl",         32'(ctl_bad), 32'h0);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_tile_writer.md
# vga_tile_writer

Write-side counterpart of the VGA address translator: fills the three 150x150 image tiles in video memory from a pixel stream produced by the vector processor. A `start` pulse selects a tile; the block then accepts exactly 22500 pixels over a valid/ready handshake and emits one registered memory write per accepted pixel. It sits between the processor's output stream and the write port of the dual-port video RAM; the translator owns the read port.

## Interface
- `TILE_W`, 150, tile width in pixels
- `TILE_H`, 150, tile height in pixels
- `ADDR_W`, 17, video memory address width
- `DATA_W`, 8, pixel width

Ports:
- `clock25`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to fill a tile; honoured only in IDLE
- `tile_sel`  in  2  tile index 0..2; sampled with `start`
- `abort`  in  1  abandons the current fill
- `pix_data`  in  DATA_W  pixel value
- `pix_valid`  in  1  `pix_data` is valid
- `pix_ready`  out  1  block accepts a pixel this cycle
- `mem_address`  out  ADDR_W  write address
- `mem_data`  out  DATA_W  write data
- `mem_we`  out  1  write strobe
- `busy`  out  1  fill in progress
- `done`  out  1  one-cycle pulse when the fill completes
- `err`  out  1  one-cycle pulse when `start` is rejected

## Operation
- Tile bases: 0x00000, 0x057E4 (22500) and 0x0AFC8 (45000). Blank address 0x107AC always holds zero.
- The address for the pixel at (col,row) is base + row*150 + col. It is produced by an incrementing pointer; no multiplier.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - `start` with `tile_sel`<3: load the pointer with the tile base, set col=row=0, go to FILL.
  - `start` with `tile_sel`=3: pulse `err` for one cycle and stay in IDLE.
- FILL:
  - `pix_ready`=1.
  - On `pix_valid`&&`pix_ready`, increment the pointer and col. At col=149, wrap col to 0 and increment row.
  - The handshake on (149,149) moves the FSM to DONE.
- DONE: lasts one cycle, `done`=1, then returns to IDLE.
- `abort` in FILL:
  - Return to IDLE on the next edge with no `done`.
  - A handshake in the same cycle is still written.
  - `abort` has priority over the last-pixel transition.
- `start` in FILL or DONE is ignored, with no `err`.
- `busy` = (state != IDLE).
- Widths: pointer ADDR_W bits; col and row 8 bits each. The pointer never exceeds base+22499.

## Timing
- Reset values:
  - state IDLE
  - `pix_ready`=0, `mem_we`=0, `busy`=0, `done`=0, `err`=0
  - `mem_data`=0
  - `mem_address`=0x107AC
- Handshake at edge N: `mem_we`=1 with the matching `mem_address`/`mem_data` during cycle N+1 (registered, latency 1).
- No handshake: `mem_we`=0 the next cycle. `mem_address`/`mem_data` hold their last values.
- `pix_ready` is decoded from registered state only; there is no combinational path from `pix_valid`.
- `start` at edge N: `busy`=1 and `pix_ready`=1 from cycle N+1.
- Last handshake at edge N:
  - the final write and `done` both occur in cycle N+1
  - `pix_ready`=0 from cycle N+1
  - IDLE again at N+2
- Throughput: one pixel per cycle; a full tile takes a minimum of 22500 cycles.
- `err` is asserted in the cycle after the rejected `start`.
- `reset` mid-fill: all outputs return to reset values on the next edge. A pending write is dropped.

## Structure
- Shared package `vga_tile_pkg`:
  - TILE_W, TILE_H, TILE_PIXELS=22500
  - TILE_BASE[0..2], BLANK_ADDR=0x107AC
  - FSM state enum
- The translator uses the same package constants.
- Sub-module `tile_raster_counter`:
  - col/row counters with clear and enable inputs
  - outputs `col`, `row` and `last` (combinational, high at (149,149))

## Test plan
- Reset, then idle: `mem_address`=0x107AC, and all strobes and `pix_ready` stay 0 for 10 cycles.
- `start`, `tile_sel`=1, with 22500 back-to-back pixels (value = index mod 256):
  - first write at 0x057E4 with data 0x00; write for index 150 at 0x0587A
  - last write at 0x0AFC7 with data 0xE3
  - `done` in the same cycle as the last write; exactly 22500 `mem_we` pulses.
- `tile_sel`=2 with `pix_valid` toggling every other cycle: addresses are contiguous from 0x0AFC8 with no gaps or duplicates, and `mem_we` appears only after a handshake.
- `start` with `tile_sel`=3: `err` pulses once, `busy` stays 0, and there are no writes.
- `tile_sel`=0, `abort` after 300 pixels: the last write is at 0x0012B, `busy` is 0 next cycle, and there is no `done`. A `start` during FILL produces no `err` and no restart.
- `reset` asserted at pixel 1000 of tile 0: `mem_we` is 0 on the next edge and `mem_address`=0x107AC. A new fill of tile 0 then starts at 0x00000.
